// File: rtl/attn_result_streamer_if.sv
// Stream interface for the attention result drain: one DW-bit word per beat,
// tagged with its index and an end-of-frame flag, under valid/ready flow control.
interface attn_result_streamer_if #(
    parameter int DW   = 16,
    parameter int IDXW = 5
);
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic [IDXW-1:0] out_idx;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        output out_idx,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        input  out_idx,
        output out_ready
    );
endinterface

// File: rtl/attn_result_streamer.sv
// attn_result_streamer: captures the attention core's full result bus on the
// rising edge of its completion level, then streams the captured words out one
// per accepted beat. Optional macro ATTN_STREAM_CHECKSUM_EN appends one extra
// beat carrying the XOR of all captured words (needs IDXW wide enough to index it).
module attn_result_streamer #(
    parameter int WORDS = 32,
    parameter int DW    = 16,
    parameter int IDXW  =
`ifdef ATTN_STREAM_CHECKSUM_EN
        6
`else
        5
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WORDS*DW-1:0]    res_in,
    input  logic                   res_done,
    attn_result_streamer_if.master s,
    output logic                   busy,
    output logic                   overrun
);

    // Buffer address width; the index may be one bit wider to reach the checksum beat.
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;
`ifdef ATTN_STREAM_CHECKSUM_EN
    localparam int NBEATS = WORDS + 1;
`else
    localparam int NBEATS = WORDS;
`endif
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBEATS - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                     state_q, state_d;
    logic                       done_q, done_d;
    logic [IDXW-1:0]            idx_q, idx_d;
    logic                       overrun_q, overrun_d;
    logic [WORDS-1:0][DW-1:0]   buf_q, buf_d;
    logic                       done_rise;
    logic                       xfer;
`ifdef ATTN_STREAM_CHECKSUM_EN
    logic [DW-1:0]              csum_q, csum_d;
    logic [DW-1:0]              res_csum;

    // XOR of the incoming words, taken straight from the bus so it lands with the capture.
    always_comb begin
        res_csum = '0;
        for (int i = 0; i < WORDS; i++) begin
            res_csum = res_csum ^ res_in[i*DW +: DW];
        end
    end
`endif

    // Next-state: capture on done edge when idle, advance index on each accepted beat.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        buf_d     = buf_q;
        done_d    = res_done;
`ifdef ATTN_STREAM_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        done_rise = res_done & ~done_q;
        xfer      = (state_q == STREAM) & s.out_ready;
        case (state_q)
            IDLE: begin
                if (done_rise) begin
                    buf_d   = res_in;
`ifdef ATTN_STREAM_CHECKSUM_EN
                    csum_d  = res_csum;
`endif
                    idx_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // A new result while draining is flagged, never loaded; this
                // includes a rise on the same edge as the final transfer.
                if (done_rise) overrun_d = 1'b1;
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers, cleared asynchronously so a reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end

    // Data buffer has no reset: its contents only matter once a capture has happened.
    always_ff @(posedge clk) begin
        buf_q  <= buf_d;
`ifdef ATTN_STREAM_CHECKSUM_EN
        csum_q <= csum_d;
`endif
    end

    // Output view: word selected by index, forced to zero outside a frame.
    always_comb begin
        s.out_valid = (state_q == STREAM);
        s.out_idx   = idx_q;
        s.out_last  = (state_q == STREAM) && (idx_q == LAST_IDX);
        s.out_data  = '0;
        if (state_q == STREAM) begin
`ifdef ATTN_STREAM_CHECKSUM_EN
            if (idx_q == IDXW'(WORDS)) s.out_data = csum_q;
            else                       s.out_data = buf_q[idx_q[AW-1:0]];
`else
            s.out_data = buf_q[idx_q[AW-1:0]];
`endif
        end
        busy    = (state_q == STREAM);
        overrun = overrun_q;
    end

endmodule
